uart_rx_deser: RTL and testbench
================================

Name: uart_rx_deser

Overview:
Oversampling UART receiver that deserialises the serial line (typically looped back from the TX stage's TX_OUT) into parallel bytes. It sits directly downstream of the UART transmitter. It produces P_DATA_OUT, PAR_OUT and RX_DONE for the UART monitor and scoreboard, and flags parity and stop-bit errors. Frame format: 1 start, 8 data bits LSB first, optional parity, 1 stop.

Parameters:
OVERSAMPLE, 8, clk cycles per bit; even, ≥4.
DATA_W, 8, data bits per frame; taken from the package constant.

Ports:
clk  in  1  sole clock, rising edge
reset  in  1  synchronous, active-low reset
RX_IN  in  1  serial line, idle high, asynchronous to frame timing
PAR_EN  in  1  1 = parity bit present
PAR_TYP  in  1  0 = even, 1 = odd
P_DATA_OUT  out  DATA_W  last good received byte
PAR_OUT  out  1  received parity bit of last frame (0 when PAR_EN=0)
RX_DONE  out  1  1-cycle pulse: good frame delivered
PAR_ERR  out  1  1-cycle pulse: parity mismatch
STP_ERR  out  1  1-cycle pulse: stop bit sampled low
RX_BUSY  out  1  high while state != IDLE

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE; all outputs 0; sync flops 1; counters 0. Reset mid-frame abandons the frame with no pulses.
- RX_IN passes through a 2-FF synchroniser (rx_s) before any use. This adds 2 cycles of latency.
- edge_cnt runs 0..OVERSAMPLE-1 and wraps once per bit. bit_cnt counts data bits 0..DATA_W-1.
- The cycle where IDLE sees rx_s=0 is edge_cnt 0 of the start bit. Leave IDLE for START and latch PAR_EN/PAR_TYP in that cycle. Mid-frame changes to these inputs are ignored.
- Bit value: majority of 3 rx_s samples at edge_cnt OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The state acts on the value at edge_cnt = OVERSAMPLE-1.
- START: majority=1 means a glitch. Return to IDLE with no pulses. Otherwise go to DATA.
- DATA: shift the bit in LSB first. After bit DATA_W-1, go to PARITY if PAR_EN is latched, else STOP.
- PARITY: expected parity = XOR of the data bits (even) or its inverse (odd). Store the received bit and record a mismatch.
- STOP: on the last cycle of the stop bit, update outputs as follows, then go to IDLE. A new start edge is accepted from the very next cycle (back-to-back frames).
  - Stop=1 and no parity mismatch: P_DATA_OUT ← shift reg, PAR_OUT ← received parity (0 if disabled), RX_DONE pulses.
  - Parity mismatch: PAR_ERR pulses, P_DATA_OUT holds, RX_DONE stays 0.
  - Stop=0: STP_ERR pulses, P_DATA_OUT holds, RX_DONE stays 0. Both error pulses may assert together.
- Latency: pulses are registered and high for exactly 1 cycle. The rising edge follows the clk edge that first registers RX_IN low by N·OVERSAMPLE+2 cycles, where N = 10 (no parity) or 11 (parity).
- Line held low forever: start → 8 zero data bits → STP_ERR → IDLE, which sees rx_s=0 and restarts immediately. Each 10/11-bit period repeats STP_ERR and never gives RX_DONE.
- P_DATA_OUT and PAR_OUT are stable between RX_DONE pulses.

Decomposition:
- uart_pkg holds:
  - rx_state_e enum {IDLE, START, DATA, PARITY, STOP}
  - DATA_W = 8
  - parity type constants PAR_EVEN = 0, PAR_ODD = 1
- Sub-module uart_rx_sampler contains edge_cnt, the 3-sample majority vote, and a bit_tick/bit_val pair (value valid at edge_cnt = OVERSAMPLE-1).
- uart_rx_deser keeps the FSM, shift register, parity check and output registers.

Test Plan:
1. OVERSAMPLE=8, PAR_EN=1, PAR_TYP=0, byte 0xA5 with parity bit 0 and stop bit 1 → RX_DONE 90 cycles after RX_IN falls; P_DATA_OUT=0xA5, PAR_OUT=0, no errors.
2. PAR_EN=1, PAR_TYP=1, byte 0x3C sent with parity 0 (wrong; correct is 1) → PAR_ERR pulse, RX_DONE=0, P_DATA_OUT keeps the previous 0xA5.
3. PAR_EN=0, byte 0x81 with stop bit 0 → STP_ERR pulse at cycle 82, no RX_DONE. Then a valid 0x7E frame → RX_DONE, P_DATA_OUT=0x7E.
4. 3-cycle low glitch on idle RX_IN → RX_BUSY high for 8 cycles, then IDLE with no pulses.
5. Two back-to-back frames 0x55 and 0xAA, PAR_EN=0, no idle gap → two RX_DONE pulses 80 cycles apart, correct bytes.
6. reset=0 asserted at bit 4 of a frame → next cycle: all outputs 0, RX_BUSY=0. A fresh 0x12 frame then receives correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int DATA_W = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_deser_if.sv
// Serial line, frame configuration and received-frame results of the UART receiver.
interface uart_rx_deser_if;
  import uart_pkg::*;

  logic              RX_IN;
  logic              PAR_EN;
  logic              PAR_TYP;
  logic [DATA_W-1:0] P_DATA_OUT;
  logic              PAR_OUT;
  logic              RX_DONE;
  logic              PAR_ERR;
  logic              STP_ERR;
  logic              RX_BUSY;

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA_OUT, PAR_OUT, RX_DONE, PAR_ERR, STP_ERR, RX_BUSY
  );

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA_OUT, PAR_OUT, RX_DONE, PAR_ERR, STP_ERR, RX_BUSY
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit oversampling counter and 3-sample majority vote.
// bit_tick_o/bit_val_o are registered, so they appear one cycle after the last sample slot of a bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  input  logic run_i,
  output logic rx_s_o,
  output logic bit_tick_o,
  output logic bit_val_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_S2   = CW'(OVERSAMPLE / 2 + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] edge_cnt_q, edge_cnt_d;
  logic          s0_q, s1_q, maj_q, maj_d;
  logic          tick_q, val_q;
  logic          rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    edge_cnt_d = '0;
    if (run_i && edge_cnt_q != CNT_LAST) edge_cnt_d = edge_cnt_q + 1'b1;
    // the third sample may land on the tick slot when OVERSAMPLE is 4
    maj_d = maj_q;
    if (edge_cnt_q == CNT_S2) maj_d = majority3(s0_q, s1_q, rx_s);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q     <= 2'b11;
      edge_cnt_q <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      maj_q      <= 1'b1;
      tick_q     <= 1'b0;
      val_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx_i};
      edge_cnt_q <= edge_cnt_d;
      if (edge_cnt_q == CNT_S0) s0_q <= rx_s;
      if (edge_cnt_q == CNT_S1) s1_q <= rx_s;
      maj_q      <= maj_d;
      tick_q     <= (edge_cnt_q == CNT_LAST);
      val_q      <= maj_d;
    end
  end

  assign rx_s_o     = rx_s;
  assign bit_tick_o = tick_q;
  assign bit_val_o  = val_q;

endmodule

// File: rtl/uart_rx_deser.sv
// Oversampling UART receiver: frame FSM, data shift register, parity check and result registers.
//   state  | meaning
//   IDLE   | line idle, waiting for rx_s low
//   START  | start bit; a high majority is a glitch
//   DATA   | shifting DATA_W bits in, LSB first
//   PARITY | capturing and checking the parity bit
//   STOP   | stop bit; publishes the frame result
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_deser_if.slave  rx_if
);

  localparam int BCW = $clog2(DATA_W);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic              par_rx_q, par_rx_d, perr_q, perr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              par_out_q, par_out_d;
  logic              done_q, done_d, par_err_q, par_err_d, stp_err_q, stp_err_d;
  logic              rx_s, bit_tick, bit_val, run, begin_frame;

  assign run = (state_d != IDLE);

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk        (clk),
    .reset      (reset),
    .rx_i       (rx_if.RX_IN),
    .run_i      (run),
    .rx_s_o     (rx_s),
    .bit_tick_o (bit_tick),
    .bit_val_o  (bit_val)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    par_rx_d    = par_rx_q;
    perr_d      = perr_q;
    data_out_d  = data_out_q;
    par_out_d   = par_out_q;
    done_d      = 1'b0;
    par_err_d   = 1'b0;
    stp_err_d   = 1'b0;
    begin_frame = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin_frame = 1'b1;
      end
      START: begin
        if (bit_tick) state_d = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = {bit_val, shift_q[DATA_W-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          par_rx_d = bit_val;
          perr_d   = bit_val != ((^shift_q) ^ (par_typ_q == PAR_ODD));
          state_d  = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (bit_val && !perr_q) begin
            data_out_d = shift_q;
            par_out_d  = par_en_q & par_rx_q;
            done_d     = 1'b1;
          end
          par_err_d = perr_q;
          stp_err_d = !bit_val;
          // the tick cycle is already edge_cnt 0 of the next bit slot, so a low line starts a frame here
          if (!rx_s) begin_frame = 1'b1;
          else       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (begin_frame) begin
      state_d   = START;
      par_en_d  = rx_if.PAR_EN;
      par_typ_d = rx_if.PAR_TYP;
      bit_cnt_d = '0;
      par_rx_d  = 1'b0;
      perr_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_rx_q   <= 1'b0;
      perr_q     <= 1'b0;
      data_out_q <= '0;
      par_out_q  <= 1'b0;
      done_q     <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_rx_q   <= par_rx_d;
      perr_q     <= perr_d;
      data_out_q <= data_out_d;
      par_out_q  <= par_out_d;
      done_q     <= done_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  assign rx_if.P_DATA_OUT = data_out_q;
  assign rx_if.PAR_OUT    = par_out_q;
  assign rx_if.RX_DONE    = done_q;
  assign rx_if.PAR_ERR    = par_err_q;
  assign rx_if.STP_ERR    = stp_err_q;
  assign rx_if.RX_BUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser: frames push expected results, a negedge monitor pops and compares.
module tb_uart_rx_deser;
  import uart_pkg::*;

  localparam int OS = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_rx_deser_if rx_if();

  uart_rx_deser #(.OVERSAMPLE(OS)) dut (
    .clk   (clk),
    .reset (reset),
    .rx_if (rx_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       done;
    logic       perr;
    logic       serr;
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_par  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic hold_bit(input logic b);
    rx_if.RX_IN = b;
    repeat (OS) @(posedge clk);
    #1;
  endtask

  // Call at posedge+1. flip toggles PAR_EN/PAR_TYP after the start bit, which the DUT must ignore.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic pbit, input logic stopb, input logic flip);
    exp_t e;
    logic good_par;
    rx_if.PAR_EN  = pen;
    rx_if.PAR_TYP = ptyp;
    good_par = (^d) ^ ptyp;
    e.cyc  = cyc + 1 + (pen ? 11 : 10) * OS + 2;
    e.perr = pen && (pbit != good_par);
    e.serr = !stopb;
    e.done = !e.perr && !e.serr;
    if (e.done) begin
      last_data = d;
      last_par  = pen ? pbit : 1'b0;
    end
    e.data = last_data;
    e.par  = last_par;
    sb.push_back(e);
    hold_bit(1'b0);
    if (flip) begin
      rx_if.PAR_EN  = ~pen;
      rx_if.PAR_TYP = ~ptyp;
    end
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
    if (pen) hold_bit(pbit);
    hold_bit(stopb);
    rx_if.RX_IN = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(rx_if.P_DATA_OUT), 32'h0);
    check({tag, "_par"},  32'(rx_if.PAR_OUT), 32'h0);
    check({tag, "_done"}, 32'(rx_if.RX_DONE), 32'h0);
    check({tag, "_perr"}, 32'(rx_if.PAR_ERR), 32'h0);
    check({tag, "_serr"}, 32'(rx_if.STP_ERR), 32'h0);
    check({tag, "_busy"}, 32'(rx_if.RX_BUSY), 32'h0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && (rx_if.RX_DONE || rx_if.PAR_ERR || rx_if.STP_ERR)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: done=%0b perr=%0b serr=%0b at cycle %0d, none expected",
                 rx_if.RX_DONE, rx_if.PAR_ERR, rx_if.STP_ERR, cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("rx_done", 32'(rx_if.RX_DONE), 32'(e.done));
        check("par_err", 32'(rx_if.PAR_ERR), 32'(e.perr));
        check("stp_err", 32'(rx_if.STP_ERR), 32'(e.serr));
        check("p_data_out", 32'(rx_if.P_DATA_OUT), 32'(e.data));
        check("par_out", 32'(rx_if.PAR_OUT), 32'(e.par));
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL pulse_timeout: no pulse seen, expected one at cycle %0d", e.cyc);
    end
  end

  int busy_cnt;

  initial begin
    rx_if.RX_IN   = 1'b1;
    rx_if.PAR_EN  = 1'b0;
    rx_if.PAR_TYP = PAR_EVEN;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    gap(4);

    // good 0xA5, even parity bit 0
    send_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    gap(20);
    // 0x3C odd parity sent as 0: parity error, data holds
    send_frame(8'h3C, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b0);
    gap(20);
    // 0x81 with a low stop bit, then a good 0x7E with config toggled mid-frame
    send_frame(8'h81, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0);
    gap(20);
    send_frame(8'h7E, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1);
    gap(20);
    // good odd-count byte with even parity: PAR_OUT must be 1
    send_frame(8'h07, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b1);
    gap(20);

    // 3-cycle low glitch on an idle line
    rx_if.RX_IN = 1'b0;
    gap(3);
    rx_if.RX_IN = 1'b1;
    busy_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (rx_if.RX_BUSY) busy_cnt++;
    end
    check("glitch_busy_cycles", 32'(busy_cnt), 32'd8);
    @(posedge clk); #1;

    // back-to-back frames, no idle gap
    send_frame(8'h55, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    send_frame(8'hAA, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    gap(20);

    // reset during data bit 4 of a frame
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(i[0]);
    check("busy_mid_frame", 32'(rx_if.RX_BUSY), 32'h1);
    reset = 1'b0;
    rx_if.RX_IN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midreset");
    last_data = 8'h00;
    last_par  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    gap(4);
    send_frame(8'h12, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    gap(10);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    check("final_data", 32'(rx_if.P_DATA_OUT), 32'h12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
